// File: rtl/sys_arr_out_collector_if.sv
// sys_arr_out_collector_if
// Bottom-edge bus between the systolic array, the tile controller and the
// output collector.
//   start/num_rows/base_addr : tile capture request (controller -> collector)
//   maccin/activein          : per-column results and valids (array -> collector)
//   out_data/out_valid/out_addr : aligned result row and buffer address
//   busy/done/err            : tile status
// master: the driving side (array + controller). slave: the collector.
interface sys_arr_out_collector_if #(
    parameter int unsigned width_height = 2
);
    logic                         start;
    logic [7:0]                   num_rows;
    logic [7:0]                   base_addr;
    logic [16*width_height-1:0]   maccin;
    logic [width_height-1:0]      activein;
    logic [16*width_height-1:0]   out_data;
    logic                         out_valid;
    logic [7:0]                   out_addr;
    logic                         busy;
    logic                         done;
    logic                         err;

    modport master (
        output start, num_rows, base_addr, maccin, activein,
        input  out_data, out_valid, out_addr, busy, done, err
    );

    modport slave (
        input  start, num_rows, base_addr, maccin, activein,
        output out_data, out_valid, out_addr, busy, done, err
    );
endinterface

// File: rtl/sys_arr_out_collector.sv
// sys_arr_out_collector
// De-skews the per-column result streams leaving the bottom of the systolic
// array into aligned rows, counts a programmed number of rows per tile and
// generates sequential output-buffer write addresses.
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high
//   bus_io : sys_arr_out_collector_if.slave (start/num_rows/base_addr in,
//            maccin/activein in, out_data/out_valid/out_addr/busy/done/err out)
// Configuration macro: COLLECTOR_RELU_EN -- when defined, negative column
// words are replaced by zero at the output register.
module sys_arr_out_collector #(
    parameter int unsigned width_height = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    sys_arr_out_collector_if.slave bus_io
);
    localparam int unsigned W  = width_height;
    localparam int unsigned DW = 16 * width_height;

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e          state_q, state_d;
    logic [7:0]      num_rows_q, num_rows_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      out_addr_q, out_addr_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [DW-1:0]   dsk_data;
    logic [W-1:0]    dsk_valid;
    logic [DW-1:0]   row_word;
    logic            row_v;
    logic            last_row;

    // Column c is delayed by W-1-c stages so that every column lines up with
    // the last column, which arrives W-1 cycles after column 0.
    for (genvar c = 0; c < W; c++) begin : g_col
        localparam int unsigned Stages = W - 1 - c;
        if (Stages == 0) begin : g_pass
            assign dsk_data[16*c +: 16] = bus_io.maccin[16*c +: 16];
            assign dsk_valid[c]         = bus_io.activein[c];
        end else begin : g_dly
            logic [Stages-1:0][15:0] data_q;
            logic [Stages-1:0]       vld_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q <= '0;
                    vld_q  <= '0;
                end else begin
                    data_q[0] <= bus_io.maccin[16*c +: 16];
                    vld_q[0]  <= bus_io.activein[c];
                    for (int i = 1; i < Stages; i++) begin
                        data_q[i] <= data_q[i-1];
                        vld_q[i]  <= vld_q[i-1];
                    end
                end
            end
            assign dsk_data[16*c +: 16] = data_q[Stages-1];
            assign dsk_valid[c]         = vld_q[Stages-1];
        end
    end

    always_comb begin
        row_word = dsk_data;
`ifdef COLLECTOR_RELU_EN
        for (int c = 0; c < W; c++) begin
            if (dsk_data[16*c+15]) begin
                row_word[16*c +: 16] = 16'h0000;
            end
        end
`endif
    end

    // Column 0's delayed valid defines the aligned row; the last column's
    // live valid must agree with it or the array's skew is broken.
    assign row_v    = dsk_valid[0];
    assign last_row = (cnt_q + 8'd1) == num_rows_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    state_d = (bus_io.num_rows == 8'd0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                if (row_v && last_row) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        num_rows_d  = num_rows_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    num_rows_d = bus_io.num_rows;
                    cnt_d      = 8'd0;
                    addr_d     = bus_io.base_addr;
                    err_d      = 1'b0;
                    done_d     = (bus_io.num_rows == 8'd0);
                end
            end
            StCollect: begin
                if (row_v) begin
                    out_data_d  = row_word;
                    out_valid_d = 1'b1;
                    out_addr_d  = addr_q;
                    addr_d      = addr_q + 8'd1;
                    cnt_d       = cnt_q + 8'd1;
                    done_d      = last_row;
                end
            end
            default: ;
        endcase
        // Error conditions override the clear on start in the same cycle.
        if ((row_v != bus_io.activein[W-1]) || (row_v && (state_q != StCollect))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_rows_q  <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            num_rows_q  <= num_rows_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus_io.out_data  = out_data_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_addr  = out_addr_q;
    assign bus_io.done      = done_q;
    assign bus_io.err       = err_q;
    assign bus_io.busy      = (state_q != StIdle);
endmodule

// File: doc/sys_arr_out_collector.md
# sys_arr_out_collector

- Sits at the bottom edge of the systolic array and consumes its per-column `maccout` and `activeout` streams.
- Column c results leave the array c cycles after column 0. This block de-skews them so each result row is presented as one aligned word.
- Under a start/done handshake it counts a programmed number of result rows and produces a sequential write address for the output buffer.
- It is the reading end of the array's bottom-edge interface.

## Interface
- `width_height`, 2, array dimension; sets the column count (matches the array).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a tile capture; sampled only in IDLE.
- `num_rows`  in  8  number of result rows to collect; sampled with `start`.
- `base_addr`  in  8  first output-buffer address; sampled with `start`.
- `maccin`  in  16*width_height  from array `maccout`; column 0 in LSBs, signed 16-bit per column.
- `activein`  in  width_height  from array `activeout`; bit c qualifies column c.
- `out_data`  out  16*width_height  aligned result row; column 0 in LSBs.
- `out_valid`  out  1  `out_data` and `out_addr` valid this cycle.
- `out_addr`  out  8  output-buffer address for the current row.
- `busy`  out  1  high in COLLECT and DONE.
- `done`  out  1  one-cycle pulse when the last row is presented.
- `err`  out  1  sticky flag for a skew mismatch or a stray row; cleared by `start`.

## Operation
- **Deskew.**
  - Column c passes through `width_height-1-c` register stages, each carrying the 16-bit word and its valid bit.
  - Column `width_height-1` has no stage.
  - All columns then feed one output register.
- **Aligned-row valid.** `row_v` is the delayed valid of column 0.
  - If `row_v` differs from `activein[width_height-1]` at a load edge, set `err`.
  - The row is still treated as valid when `row_v` is 1.
- **FSM states:** IDLE, COLLECT, DONE.
  - **IDLE.** On `start`, latch `num_rows`, set `cnt` to 0 and `addr` to `base_addr`.
    - If `num_rows` is 0, go to DONE.
    - Otherwise go to COLLECT.
    - Clear `err`.
  - **COLLECT.** On each edge with `row_v`=1:
    - load `out_data` and set `out_valid`=1 with `out_addr`=`addr`;
    - increment `addr` (wraps 255→0) and `cnt`;
    - if `cnt+1` equals `num_rows`, go to DONE.
  - **DONE.** Lasts one cycle, then goes to IDLE.
- **`done` pulse.**
  - Normal completion: `done` is high in the same cycle that the last row's `out_valid` is high.
  - `num_rows`=0: `done` is high for the DONE cycle only, with no `out_valid`.
- **Boundary behaviour.**
  - An aligned valid row while in IDLE or DONE is discarded: no `out_valid`, and `err` is set.
  - `start` while in COLLECT or DONE is ignored.
  - Rows beyond `num_rows` arrive while in DONE or IDLE, so they are discarded and set `err`.
  - Reset mid-tile: all state and outputs clear immediately. A partial tile is lost and no `done` is produced.

## Timing
- **Reset values:** `out_data`=0, `out_valid`=0, `out_addr`=0, `busy`=0, `done`=0, `err`=0. All delay-stage valid bits are 0 and the FSM is in IDLE.
- **Latency.** If the column 0 word is sampled at edge k, the row is visible during the cycle after edge `k+width_height-1`.
- **Start.** A `start` at edge s makes `busy` high from s+1.
  - Rows whose output load edge is at s+1 or later are counted.
  - Rows loaded at edge s or earlier are treated as IDLE rows.
- `out_valid` is a single-cycle pulse per row. Back-to-back rows give consecutive pulses with no bubble.
- There is no backpressure: the array cannot be stalled, so the downstream buffer must accept one row per cycle.
- `busy` falls one cycle after `done`.

## Configuration
- **Macro:** `COLLECTOR_RELU_EN`.
- **Defined:** at the output register, each 16-bit column word with bit 15 set is replaced by 0. Non-negative words pass through unchanged.
- **Undefined:** words pass through unmodified.
- Valid, count, address and `err` behaviour are identical in both builds.

## Test plan
All scenarios use `width_height`=2.
- **Basic tile.** Reset, then `start` with `num_rows`=3 and `base_addr`=0x10. Feed col0 words 1, 2, 3 on edges k..k+2 and col1 words 4, 5, 6 on edges k+1..k+3, with matching `activein`. Expect:
  - `out_valid` in 3 consecutive cycles after edges k+1..k+3;
  - `out_data` = {4,1}, {5,2}, {6,3};
  - `out_addr` = 0x10, 0x11, 0x12;
  - `done` with the third row, `err`=0.
- **Zero rows.** `start` with `num_rows`=0 gives `done`=1 the next cycle, `busy` high for that cycle only, and no `out_valid`.
- **Skew error and stray row.**
  - Drive col0 active but not col1 one cycle later: expect `err`=1 and the row still counted.
  - With a row arriving in IDLE: expect no `out_valid` and `err`=1.
  - The next `start` clears `err`.
- **Wrap and reset.**
  - `base_addr`=0xFF with 2 rows gives `out_addr` 0xFF then 0x00.
  - Asserting `reset` after the first row clears all outputs at once, with no `done`.
- **ReLU.** With `COLLECTOR_RELU_EN` defined, col0=0xFFF6 and col1=0x0007 give `out_data`=0x00070000. Without the macro they give 0x0007FFF6.
